cva6_fifo_v4: RTL and testbench

CVA6_FIFO_V4 -- requirements
Module: cva6_fifo_v4

---
 rtl/cva6_fifo_v4.sv | 98 +++++++++
 tb/tb_cva6_fifo_v4.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cva6_fifo_v4.sv
// Synchronous FIFO with an optional fall-through path, threshold flags and sticky error flags.
// Storage, pointers and count clear asynchronously. Storage is held across a flush.
module cva6_fifo_v4 #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
   parameter int unsigned ALM_EMPTY_TH = 1,
   localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  testmode_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic [ADDR_DEPTH:0]   usage_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam logic [ADDR_DEPTH-1:0] PTR_LAST  = ADDR_DEPTH'(DEPTH - 1);
   localparam logic [ADDR_DEPTH:0]   CNT_FULL  = (ADDR_DEPTH + 1)'(DEPTH);
   localparam logic [ADDR_DEPTH:0]   CNT_AF_TH = (ADDR_DEPTH + 1)'(ALM_FULL_TH);
   localparam logic [ADDR_DEPTH:0]   CNT_AE_TH = (ADDR_DEPTH + 1)'(ALM_EMPTY_TH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
   logic [ADDR_DEPTH:0]   count_q;
   logic                  overflow_q, underflow_q;

   logic cnt_zero, ft_active, push_acc, pop_acc;
   logic unused_testmode;

   assign unused_testmode = testmode_i;

   assign cnt_zero  = (count_q == '0);
   assign ft_active = FALL_THROUGH && cnt_zero && push_i;

   assign full_o         = (count_q == CNT_FULL);
   assign empty_o        = cnt_zero && !ft_active;
   assign almost_full_o  = (count_q >= CNT_AF_TH);
   assign almost_empty_o = (count_q <= CNT_AE_TH);
   assign usage_o        = count_q;
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;

   // A fall-through push that is popped in the same cycle bypasses storage entirely.
   assign push_acc = push_i && !full_o && !(ft_active && pop_i) && !flush_i;
   assign pop_acc  = pop_i && !empty_o && !ft_active && !flush_i;

   assign data_o = ft_active ? data_i : mem_q[rd_ptr_q];

   function automatic logic [ADDR_DEPTH-1:0] ptr_next(input logic [ADDR_DEPTH-1:0] p);
      return (p == PTR_LAST) ? '0 : ADDR_DEPTH'(p + 1'b1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '{default: '0};
      end else if (push_acc) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (flush_i) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push_acc) wr_ptr_q <= ptr_next(wr_ptr_q);
         if (pop_acc)  rd_ptr_q <= ptr_next(rd_ptr_q);
         case ({push_acc, pop_acc})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push_i && full_o)  overflow_q  <= 1'b1;
         if (pop_i && empty_o)  underflow_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cva6_fifo_v4.sv
// Directed bench: one FIFO without fall-through and one with, both DEPTH=5, DATA_WIDTH=16.
module tb_cva6_fifo_v4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        flush0, push0, pop0;
   logic [15:0] din0, dout0;
   logic        full0, empty0, af0, ae0, ovf0, udf0;
   logic [3:0]  usage0;

   logic        flush1, push1, pop1;
   logic [15:0] din1, dout1;
   logic        full1, empty1, af1, ae1, ovf1, udf1;
   logic [3:0]  usage1;

   int tests  = 0;
   int failed = 0;

   cva6_fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(16), .DEPTH(5)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush0), .testmode_i(1'b0),
      .data_i(din0), .push_i(push0), .pop_i(pop0), .data_o(dout0),
      .full_o(full0), .empty_o(empty0), .almost_full_o(af0), .almost_empty_o(ae0),
      .usage_o(usage0), .overflow_o(ovf0), .underflow_o(udf0)
   );

   cva6_fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(16), .DEPTH(5)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1), .testmode_i(1'b1),
      .data_i(din1), .push_i(push1), .pop_i(pop1), .data_o(dout1),
      .full_o(full1), .empty_o(empty1), .almost_full_o(af1), .almost_empty_o(ae1),
      .usage_o(usage1), .overflow_o(ovf1), .underflow_o(udf1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tests++; if (empty0 !== 1'b1) begin failed++; $display("FAIL reset_empty got %b exp 1", empty0); end
      tests++; if (full0 !== 1'b0) begin failed++; $display("FAIL reset_full got %b exp 0", full0); end
      tests++; if (usage0 !== 4'd0) begin failed++; $display("FAIL reset_usage got %0d exp 0", usage0); end
      tests++; if (ae0 !== 1'b1 || af0 !== 1'b0) begin failed++; $display("FAIL reset_alm got ae=%b af=%b exp ae=1 af=0", ae0, af0); end
      tests++; if (dout0 !== 16'h0) begin failed++; $display("FAIL reset_data got %h exp 0000", dout0); end
      tests++; if (ovf0 !== 1'b0 || udf0 !== 1'b0) begin failed++; $display("FAIL reset_err got ovf=%b udf=%b exp 0 0", ovf0, udf0); end
      tests++; if (empty1 !== 1'b1 || usage1 !== 4'd0) begin failed++; $display("FAIL reset_ft got empty=%b usage=%0d exp 1 0", empty1, usage1); end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 5; i++) begin
         push0 = 1'b1; din0 = 16'(i);
         tick();
         tests++; if (usage0 !== 4'(i)) begin failed++; $display("FAIL fill_usage got %0d exp %0d", usage0, i); end
         tests++; if (af0 !== (i >= 4)) begin failed++; $display("FAIL fill_af at %0d got %b exp %b", i, af0, (i >= 4)); end
         tests++; if (full0 !== (i == 5)) begin failed++; $display("FAIL fill_full at %0d got %b exp %b", i, full0, (i == 5)); end
         tests++; if (ae0 !== (i <= 1)) begin failed++; $display("FAIL fill_ae at %0d got %b exp %b", i, ae0, (i <= 1)); end
      end
      push0 = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         pop0 = 1'b1;
         #1;
         tests++; if (dout0 !== 16'(i)) begin failed++; $display("FAIL drain_data got %h exp %h", dout0, 16'(i)); end
         tick();
      end
      pop0 = 1'b0;
      tests++; if (empty0 !== 1'b1 || usage0 !== 4'd0) begin failed++; $display("FAIL drain_empty got empty=%b usage=%0d exp 1 0", empty0, usage0); end
      tests++; if (udf0 !== 1'b0 || ovf0 !== 1'b0) begin failed++; $display("FAIL drain_err got ovf=%b udf=%b exp 0 0", ovf0, udf0); end
   endtask

   task automatic test_wrap();
      logic [15:0] q[$];
      for (int k = 0; k < 3; k++) begin
         push0 = 1'b1; din0 = 16'h0100 + 16'(k);
         q.push_back(din0);
         tick();
      end
      for (int c = 0; c < 12; c++) begin
         push0 = 1'b1; pop0 = 1'b1; din0 = 16'h0200 + 16'(c);
         #1;
         tests++; if (dout0 !== q[0]) begin failed++; $display("FAIL wrap_data cyc %0d got %h exp %h", c, dout0, q[0]); end
         tick();
         void'(q.pop_front());
         q.push_back(din0);
         tests++; if (usage0 !== 4'd3) begin failed++; $display("FAIL wrap_usage cyc %0d got %0d exp 3", c, usage0); end
      end
      push0 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         pop0 = 1'b1;
         #1;
         tests++; if (dout0 !== q[0]) begin failed++; $display("FAIL wrap_drain got %h exp %h", dout0, q[0]); end
         tick();
         void'(q.pop_front());
      end
      pop0 = 1'b0;
      tests++; if (empty0 !== 1'b1) begin failed++; $display("FAIL wrap_empty got %b exp 1", empty0); end
   endtask

   task automatic test_full_push_pop();
      for (int k = 0; k < 5; k++) begin
         push0 = 1'b1; din0 = 16'h00A0 + 16'(k);
         tick();
      end
      push0 = 1'b1; pop0 = 1'b1; din0 = 16'hFFFF;
      #1;
      tests++; if (dout0 !== 16'h00A0) begin failed++; $display("FAIL full_head got %h exp 00a0", dout0); end
      tests++; if (ovf0 !== 1'b0) begin failed++; $display("FAIL full_ovf_pre got %b exp 0", ovf0); end
      tick();
      push0 = 1'b0; pop0 = 1'b0;
      tests++; if (usage0 !== 4'd4) begin failed++; $display("FAIL full_usage got %0d exp 4", usage0); end
      tests++; if (ovf0 !== 1'b1) begin failed++; $display("FAIL full_ovf got %b exp 1", ovf0); end
      tick(); tick();
      tests++; if (ovf0 !== 1'b1) begin failed++; $display("FAIL full_ovf_sticky got %b exp 1", ovf0); end
      for (int k = 1; k < 5; k++) begin
         pop0 = 1'b1;
         #1;
         tests++; if (dout0 !== 16'h00A0 + 16'(k)) begin failed++; $display("FAIL full_order got %h exp %h", dout0, 16'h00A0 + 16'(k)); end
         tick();
      end
      pop0 = 1'b0;
      tests++; if (empty0 !== 1'b1 || ovf0 !== 1'b1 || udf0 !== 1'b0) begin failed++; $display("FAIL full_after got empty=%b ovf=%b udf=%b exp 1 1 0", empty0, ovf0, udf0); end
      flush0 = 1'b1;
      tick();
      flush0 = 1'b0;
      tests++; if (ovf0 !== 1'b0) begin failed++; $display("FAIL full_flush_ovf got %b exp 0", ovf0); end
   endtask

   task automatic test_fall_through();
      push1 = 1'b1; pop1 = 1'b1; din1 = 16'hBEEF;
      #1;
      tests++; if (dout1 !== 16'hBEEF) begin failed++; $display("FAIL ft_data got %h exp beef", dout1); end
      tests++; if (empty1 !== 1'b0) begin failed++; $display("FAIL ft_empty got %b exp 0", empty1); end
      tick();
      push1 = 1'b0; pop1 = 1'b0;
      tests++; if (usage1 !== 4'd0 || udf1 !== 1'b0) begin failed++; $display("FAIL ft_after got usage=%0d udf=%b exp 0 0", usage1, udf1); end
      push1 = 1'b1; din1 = 16'h1234;
      #1;
      tests++; if (dout1 !== 16'h1234) begin failed++; $display("FAIL ft_push_data got %h exp 1234", dout1); end
      tick();
      push1 = 1'b0;
      tests++; if (usage1 !== 4'd1 || dout1 !== 16'h1234) begin failed++; $display("FAIL ft_push_store got usage=%0d data=%h exp 1 1234", usage1, dout1); end

      push0 = 1'b1; pop0 = 1'b1; din0 = 16'hBEEF;
      #1;
      tests++; if (empty0 !== 1'b1) begin failed++; $display("FAIL nft_empty got %b exp 1", empty0); end
      tick();
      push0 = 1'b0; pop0 = 1'b0;
      tests++; if (usage0 !== 4'd1 || udf0 !== 1'b1) begin failed++; $display("FAIL nft_after got usage=%0d udf=%b exp 1 1", usage0, udf0); end
      tests++; if (dout0 !== 16'hBEEF) begin failed++; $display("FAIL nft_data got %h exp beef", dout0); end
      flush0 = 1'b1; flush1 = 1'b1;
      tick();
      flush0 = 1'b0; flush1 = 1'b0;
   endtask

   task automatic test_flush();
      pop0 = 1'b1;
      tick();
      pop0 = 1'b0;
      tests++; if (udf0 !== 1'b1) begin failed++; $display("FAIL flush_udf_set got %b exp 1", udf0); end
      for (int k = 0; k < 3; k++) begin
         push0 = 1'b1; din0 = 16'h0011 * 16'(k + 1);
         tick();
      end
      flush0 = 1'b1; push0 = 1'b1; din0 = 16'h0044;
      tick();
      flush0 = 1'b0; push0 = 1'b0;
      tests++; if (usage0 !== 4'd0 || empty0 !== 1'b1) begin failed++; $display("FAIL flush_state got usage=%0d empty=%b exp 0 1", usage0, empty0); end
      tests++; if (udf0 !== 1'b0 || ovf0 !== 1'b0) begin failed++; $display("FAIL flush_err got ovf=%b udf=%b exp 0 0", ovf0, udf0); end
      push0 = 1'b1; din0 = 16'h0055;
      tick();
      push0 = 1'b0;
      tests++; if (usage0 !== 4'd1 || dout0 !== 16'h0055) begin failed++; $display("FAIL flush_lost got usage=%0d data=%h exp 1 0055", usage0, dout0); end
      flush0 = 1'b1;
      tick();
      flush0 = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 2; k++) begin
         push0 = 1'b1; din0 = 16'h0C00 + 16'(k + 1);
         tick();
      end
      push0 = 1'b0;
      tests++; if (usage0 !== 4'd2 || dout0 !== 16'h0C01) begin failed++; $display("FAIL arst_pre got usage=%0d data=%h exp 2 0c01", usage0, dout0); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (empty0 !== 1'b1 || usage0 !== 4'd0) begin failed++; $display("FAIL arst_state got empty=%b usage=%0d exp 1 0", empty0, usage0); end
      tests++; if (dout0 !== 16'h0) begin failed++; $display("FAIL arst_data got %h exp 0000", dout0); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      flush0 = 1'b0; push0 = 1'b0; pop0 = 1'b0; din0 = '0;
      flush1 = 1'b0; push1 = 1'b0; pop1 = 1'b0; din1 = '0;
      #3;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      test_fill_drain();
      test_wrap();
      test_full_push_pop();
      test_fall_through();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
